rgb_to_grey_stream: RTL and testbench

- Frame-level colour-to-greyscale engine. Sweeps a packed-RGB source image BRAM once per start pulse and writes one greyscale pixel per address into a destination BRAM.
- Replaces the free-running address counter in top level with a start/busy/done handshake, correct read-latency alignment, selectable weighting and parametrised geometry.
- Sits between the UART-loaded image memory and the output memory, ahead of the SIFT pyramid stages.

---
 rtl/rgb_to_grey_stream.sv | 123 ++++++++++++
 tb/tb_rgb_to_grey_stream.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_to_grey_stream.sv
// Sweeps a packed-RGB source BRAM once per start pulse and writes one greyscale pixel per address.
// Writes trail their read address by READ_LATENCY+1 cycles; no backpressure, one pixel per cycle.
module rgb_to_grey_stream #(
  parameter int WIDTH        = 128,
  parameter int HEIGHT       = 128,
  parameter int CHANNEL_BITS = 4,
  parameter int OUT_BITS     = 8,
  parameter int READ_LATENCY = 2,
  localparam int ADDR_W      = $clog2(WIDTH*HEIGHT)
) (
  input  logic                      clk_100mhz,
  input  logic                      sys_rst,
  input  logic                      start,
  input  logic                      mode,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         src_addr,
  input  logic [3*CHANNEL_BITS-1:0] src_data,
  output logic [ADDR_W-1:0]         dst_addr,
  output logic [OUT_BITS-1:0]       dst_data,
  output logic                      dst_we,
  output logic [15:0]               frame_count
);

  localparam int N     = WIDTH * HEIGHT;
  localparam int MW    = CHANNEL_BITS + 10;
  localparam int G_MAX = (2 ** CHANNEL_BITS) - 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state;
  logic                    mode_q;
  logic [READ_LATENCY-1:0] vld_sr;
  logic [ADDR_W-1:0]       addr_sr [READ_LATENCY];

  logic [CHANNEL_BITS-1:0] r, g, b;
  logic [MW-1:0]           acc;
  logic [MW-1:0]           scaled;
  logic [CHANNEL_BITS-1:0] g4;
  logic [OUT_BITS-1:0]     grey;

  assign r = src_data[3*CHANNEL_BITS-1:2*CHANNEL_BITS];
  assign g = src_data[2*CHANNEL_BITS-1:CHANNEL_BITS];
  assign b = src_data[CHANNEL_BITS-1:0];

  // Weights are scaled by 256 with a +128 rounding term before the shift.
  always_comb begin
    if (mode_q)
      acc = MW'(r) * MW'(77) + MW'(g) * MW'(150) + MW'(b) * MW'(29) + MW'(128);
    else
      acc = (MW'(r) + MW'(g) + MW'(b)) * MW'(85) + MW'(128);
    scaled = acc >> 8;
    if (scaled > MW'(G_MAX))
      g4 = '1;
    else
      g4 = scaled[CHANNEL_BITS-1:0];
    grey = '0;
    for (int i = 0; i < OUT_BITS; i++)
      grey[OUT_BITS-1-i] = g4[CHANNEL_BITS-1-(i % CHANNEL_BITS)];
  end

  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      state       <= IDLE;
      mode_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      src_addr    <= '0;
      dst_addr    <= '0;
      dst_data    <= '0;
      dst_we      <= 1'b0;
      frame_count <= '0;
      vld_sr      <= '0;
      for (int k = 0; k < READ_LATENCY; k++)
        addr_sr[k] <= '0;
    end else begin
      done <= 1'b0;

      // Each address presented in READ carries a token matching the BRAM latency.
      vld_sr[0]  <= (state == READ);
      addr_sr[0] <= src_addr;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_sr[k]  <= vld_sr[k-1];
        addr_sr[k] <= addr_sr[k-1];
      end

      dst_we   <= vld_sr[READ_LATENCY-1];
      dst_addr <= addr_sr[READ_LATENCY-1];
      if (vld_sr[READ_LATENCY-1])
        dst_data <= grey;

      case (state)
        IDLE: begin
          if (start) begin
            mode_q   <= mode;
            src_addr <= '0;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          if (src_addr == LAST_ADDR)
            state <= DRAIN;
          else
            src_addr <= src_addr + ADDR_W'(1);
        end
        DRAIN: begin
          // Token-free pipeline means the final write is on dst_we this cycle.
          if (vld_sr == '0) begin
            state       <= DONE;
            done        <= 1'b1;
            busy        <= 1'b0;
            frame_count <= frame_count + 16'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_to_grey_stream.sv
// Bench: three 4x4 engines with READ_LATENCY 1, 2 and 3 share a stimulus and a BRAM image.
// Directed vectors with hand-computed greys, plus hand-written start/reset sequences.
module tb_rgb_to_grey_stream;

  localparam int NPIX = 16;
  localparam int CAP  = 512;

  logic clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  logic        sys_rst;
  logic [2:0]  start_v;
  logic        mode;
  logic        busy_v     [3];
  logic        done_v     [3];
  logic        dst_we_v   [3];
  logic [3:0]  src_addr_v [3];
  logic [3:0]  dst_addr_v [3];
  logic [11:0] src_data_v [3];
  logic [7:0]  dst_data_v [3];
  logic [15:0] fc_v       [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    rgb_to_grey_stream #(
      .WIDTH(4), .HEIGHT(4), .CHANNEL_BITS(4), .OUT_BITS(8), .READ_LATENCY(gi + 1)
    ) u_dut (
      .clk_100mhz (clk_100mhz),
      .sys_rst    (sys_rst),
      .start      (start_v[gi]),
      .mode       (mode),
      .busy       (busy_v[gi]),
      .done       (done_v[gi]),
      .src_addr   (src_addr_v[gi]),
      .src_data   (src_data_v[gi]),
      .dst_addr   (dst_addr_v[gi]),
      .dst_data   (dst_data_v[gi]),
      .dst_we     (dst_we_v[gi]),
      .frame_count(fc_v[gi])
    );
  end

  // BRAM model: engine g sees data for an address g+1 cycles later.
  logic [11:0] mem   [NPIX];
  logic [3:0]  apipe [3][3];
  always @(posedge clk_100mhz) begin
    for (int g = 0; g < 3; g++) begin
      apipe[g][0] <= src_addr_v[g];
      for (int k = 1; k < 3; k++) apipe[g][k] <= apipe[g][k-1];
    end
  end
  always_comb begin
    for (int g = 0; g < 3; g++) src_data_v[g] = mem[apipe[g][g]];
  end

  int cyc = 0;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  int         wtot     [3];
  int         dtot     [3];
  int         src0_cyc [3];
  logic [3:0] cap_addr [3][CAP];
  logic [7:0] cap_data [3][CAP];
  int         cap_cyc  [3][CAP];
  int         dcap     [3][32];

  always @(negedge clk_100mhz) begin
    for (int g = 0; g < 3; g++) begin
      if (dst_we_v[g]) begin
        if (wtot[g] < CAP) begin
          cap_addr[g][wtot[g]] = dst_addr_v[g];
          cap_data[g][wtot[g]] = dst_data_v[g];
          cap_cyc[g][wtot[g]]  = cyc;
        end
        wtot[g] = wtot[g] + 1;
      end
      if (done_v[g]) begin
        if (dtot[g] < 32) dcap[g][dtot[g]] = cyc;
        dtot[g] = dtot[g] + 1;
      end
      if (busy_v[g] && src_addr_v[g] == 4'd0) src0_cyc[g] = cyc;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int wbase [3];
  int dbase [3];
  int scyc;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NPIX; i++) mem[i] = 12'(i * 12'h111);
  endtask

  task automatic run_frame(input logic m, input logic [2:0] mask);
    int t;
    bit all;
    for (int g = 0; g < 3; g++) begin
      wbase[g] = wtot[g];
      dbase[g] = dtot[g];
    end
    mode    = m;
    start_v = mask;
    scyc    = cyc;
    tick(1);
    start_v = '0;
    t   = 0;
    all = 1'b0;
    while (!all && t < 200) begin
      tick(1);
      t++;
      all = 1'b1;
      for (int g = 0; g < 3; g++)
        if (mask[g] && dtot[g] == dbase[g]) all = 1'b0;
    end
    check("frame_done", int'(all), 1);
    tick(2);
  endtask

  // Full-frame checks against the ramp image ({i,i,i} -> {i,i}).
  task automatic check_frame(input int g);
    int l;
    l = g + 1;
    check($sformatf("dut%0d_writes", g), wtot[g] - wbase[g], NPIX);
    check($sformatf("dut%0d_dones", g), dtot[g] - dbase[g], 1);
    for (int k = 0; k < NPIX; k++) begin
      check($sformatf("dut%0d_addr%0d", g, k), int'(cap_addr[g][wbase[g]+k]), k);
      check($sformatf("dut%0d_data%0d", g, k), int'(cap_data[g][wbase[g]+k]), k * 17);
      check($sformatf("dut%0d_wcyc%0d", g, k), cap_cyc[g][wbase[g]+k] - scyc, l + 2 + k);
    end
    check($sformatf("dut%0d_src0_to_we", g), cap_cyc[g][wbase[g]] - src0_cyc[g], l + 1);
    check($sformatf("dut%0d_start_to_done", g), dcap[g][dbase[g]] - scyc, NPIX + l + 2);
  endtask

  typedef struct {
    logic        m;
    logic [11:0] pix;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int got;
    int sc2;
    int fc0;
    bit hit;

    vecs[0] = '{m: 1'b0, pix: 12'hF00, exp: 8'h55};
    vecs[1] = '{m: 1'b0, pix: 12'hFFF, exp: 8'hFF};
    vecs[2] = '{m: 1'b0, pix: 12'h000, exp: 8'h00};
    vecs[3] = '{m: 1'b1, pix: 12'h0F0, exp: 8'h99};
    vecs[4] = '{m: 1'b1, pix: 12'h00F, exp: 8'h22};
    vecs[5] = '{m: 1'b1, pix: 12'hF00, exp: 8'h55};
    vecs[6] = '{m: 1'b1, pix: 12'hFFF, exp: 8'hFF};
    vecs[7] = '{m: 1'b0, pix: 12'h123, exp: 8'h22};

    sys_rst = 1'b1;
    start_v = '0;
    mode    = 1'b0;
    fill_ramp();
    tick(3);
    sys_rst = 1'b0;
    tick(1);

    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_busy%0d", g), int'(busy_v[g]), 0);
      check($sformatf("rst_done%0d", g), int'(done_v[g]), 0);
      check($sformatf("rst_we%0d", g), int'(dst_we_v[g]), 0);
      check($sformatf("rst_src%0d", g), int'(src_addr_v[g]), 0);
      check($sformatf("rst_dst%0d", g), int'(dst_addr_v[g]), 0);
      check($sformatf("rst_data%0d", g), int'(dst_data_v[g]), 0);
      check($sformatf("rst_fc%0d", g), int'(fc_v[g]), 0);
    end

    // Ramp frame on all three latencies.
    run_frame(1'b1, 3'b111);
    for (int g = 0; g < 3; g++) begin
      check_frame(g);
      check($sformatf("fc1_dut%0d", g), int'(fc_v[g]), 1);
    end

    // Uniform-image vectors: every write in the frame must carry the expected grey.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < NPIX; i++) mem[i] = vecs[v].pix;
      run_frame(vecs[v].m, 3'b111);
      for (int g = 0; g < 3; g++) begin
        got = int'(vecs[v].exp);
        for (int k = 0; k < NPIX; k++)
          if (cap_data[g][wbase[g]+k] != vecs[v].exp) got = int'(cap_data[g][wbase[g]+k]);
        check($sformatf("vec%0d_dut%0d", v, g), got, int'(vecs[v].exp));
      end
    end

    // Stray starts mid-frame and in the done cycle, then back-to-back frame.
    fill_ramp();
    fc0 = int'(fc_v[1]);
    wbase[1] = wtot[1];
    dbase[1] = dtot[1];
    mode    = 1'b1;
    start_v = 3'b010;
    scyc    = cyc;
    tick(1);
    start_v = '0;
    tick(4);
    start_v = 3'b010;
    tick(1);
    start_v = '0;
    tick(4);
    start_v = 3'b010;
    tick(1);
    start_v = '0;
    tick(9);
    start_v = 3'b010;
    tick(1);
    sc2 = cyc;
    tick(1);
    start_v = '0;
    for (int t = 0; t < 100 && dtot[1] < dbase[1] + 2; t++) tick(1);
    tick(2);
    check("stray_done1_cyc", dcap[1][dbase[1]] - scyc, NPIX + 4);
    check("stray_dones", dtot[1] - dbase[1], 2);
    check("stray_writes", wtot[1] - wbase[1], 2 * NPIX);
    check("stray_fc", int'(fc_v[1]), fc0 + 2);
    check("frame2_start_cyc", sc2 - scyc, NPIX + 5);
    check("frame2_done_cyc", dcap[1][dbase[1]+1] - sc2, NPIX + 4);
    for (int k = 0; k < NPIX; k++) begin
      check($sformatf("f1_wcyc%0d", k), cap_cyc[1][wbase[1]+k] - scyc, 4 + k);
      check($sformatf("f2_addr%0d", k), int'(cap_addr[1][wbase[1]+NPIX+k]), k);
      check($sformatf("f2_wcyc%0d", k), cap_cyc[1][wbase[1]+NPIX+k] - sc2, 4 + k);
    end

    // Reset asserted while write 7 is on the bus.
    wbase[1] = wtot[1];
    dbase[1] = dtot[1];
    mode    = 1'b1;
    start_v = 3'b010;
    tick(1);
    start_v = '0;
    hit = 1'b0;
    for (int t = 0; t < 100 && !hit; t++) begin
      @(negedge clk_100mhz);
      if (dst_we_v[1] && dst_addr_v[1] == 4'd7) hit = 1'b1;
    end
    check("rst_hit_write7", int'(hit), 1);
    sys_rst = 1'b1;
    @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    check("midrst_we", int'(dst_we_v[1]), 0);
    check("midrst_busy", int'(busy_v[1]), 0);
    sys_rst = 1'b0;
    tick(30);
    check("midrst_writes", wtot[1] - wbase[1], 8);
    check("midrst_dones", dtot[1] - dbase[1], 0);
    check("midrst_fc", int'(fc_v[1]), 0);
    check("midrst_idle_busy", int'(busy_v[1]), 0);

    run_frame(1'b1, 3'b010);
    check_frame(1);
    check("postrst_fc", int'(fc_v[1]), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
